// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - load/store size constants and data-memory FSM state type
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_WAIT_R,
    MEM_DONE
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } mem_size_e;

  // Undefined Funct3 encodings fall back to a full word access.
  function automatic mem_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-enable/store replication and load lane extraction/extension
module lsu_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] store_rep,
  output logic [31:0] load_ext
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Halfwords only ever use addr[1]; addr[0] never shifts a halfword lane.
  assign byte_shift = load_word >> {lane, 3'b000};
  assign half_shift = load_word >> {lane[1], 4'b0000};
  assign ld_byte    = byte_shift[7:0];
  assign ld_half    = half_shift[15:0];

  always_comb begin
    be        = 4'b1111;
    store_rep = store_data;
    load_ext  = load_word;
    case (f3_size(funct3))
      SZ_B: begin
        be        = 4'b0001 << lane;
        store_rep = {4{store_data[7:0]}};
        load_ext  = funct3[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_H: begin
        be        = 4'b0011 << {lane[1], 1'b0};
        store_rep = {2{store_data[15:0]}};
        load_ext  = funct3[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_access_unit.sv
// rtl/data_mem_access_unit.sv - load/store bus sequencer with pipeline stall; MISALIGN_TRAP_EN enables misalign abort
module data_mem_access_unit
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        Funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              stall,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [31:0] CNT_LAST = 32'(TIMEOUT_CYC - 1);

  mem_state_e        state, state_n;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wdata_q;
  logic              store_q;
  logic [31:0]       cnt_q, cnt_n;
  logic              err_q, err_n;
  logic              latch_en, load_cap, tmo_clr;
  logic              misalign, tmo_hit, in_req;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata, load_ext;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    case (f3_size(Funct3))
      SZ_H:    misalign = addr[0];
      SZ_W:    misalign = (addr[1:0] != 2'b00);
      default: misalign = 1'b0;
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  assign tmo_hit = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt_q;
    err_n    = 1'b0;
    latch_en = 1'b0;
    load_cap = 1'b0;
    tmo_clr  = 1'b0;
    stall    = 1'b0;
    mem_req  = 1'b0;
    case (state)
      MEM_IDLE: begin
        cnt_n = '0;
        if (MemRead || MemWrite) begin
          stall    = 1'b1;
          latch_en = 1'b1;
          if (misalign) begin
            state_n = MEM_DONE;
            err_n   = 1'b1;
          end else begin
            state_n = MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
        if (mem_gnt) begin
          state_n = store_q ? MEM_DONE : MEM_WAIT_R;
          cnt_n   = '0;
        end else if (tmo_hit) begin
          state_n = MEM_DONE;
          err_n   = 1'b1;
          tmo_clr = 1'b1;
        end else begin
          cnt_n = cnt_q + 32'd1;
        end
      end
      MEM_WAIT_R: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          state_n  = MEM_DONE;
          load_cap = 1'b1;
        end else if (tmo_hit) begin
          state_n = MEM_DONE;
          err_n   = 1'b1;
          tmo_clr = 1'b1;
        end else begin
          cnt_n = cnt_q + 32'd1;
        end
      end
      // Strobes seen here still belong to the retiring instruction.
      MEM_DONE: state_n = MEM_IDLE;
      default:  state_n = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= MEM_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      store_q <= 1'b0;
      rdata   <= '0;
    end else begin
      state <= state_n;
      cnt_q <= cnt_n;
      err_q <= err_n;
      if (latch_en) begin
        addr_q  <= addr;
        f3_q    <= Funct3;
        wdata_q <= wdata;
        store_q <= MemWrite;
      end
      if (load_cap) rdata <= load_ext;
      else if (tmo_clr) rdata <= '0;
    end
  end

  lsu_lane_align u_lane_align (
    .funct3     (f3_q),
    .lane       (addr_q[1:0]),
    .store_data (wdata_q),
    .load_word  (mem_rdata),
    .be         (lane_be),
    .store_rep  (lane_wdata),
    .load_ext   (load_ext)
  );

  // Bus-side fields are forced to zero whenever no request is outstanding.
  assign in_req    = (state == MEM_REQ);
  assign mem_we    = in_req & store_q;
  assign mem_addr  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = in_req ? lane_be : 4'b0000;
  assign mem_wdata = in_req ? lane_wdata : 32'h0;
  assign done      = (state == MEM_DONE);
  assign bus_err   = err_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// tb/tb_data_mem_access_unit.sv - randomized self-checking bench with behavioural load/store model
module tb_data_mem_access_unit;

  localparam int TMO = 4;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] addr, wdata;
  logic        stall, done, bus_err;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_rdata;

  typedef struct {
    bit          done;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          we;
    int          req_cyc;
    int          stall_cyc;
    bit          spurious;
  } obs_t;

  data_mem_access_unit #(.ADDR_W(32), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .done(done), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach summary (got hang, required finish)");
    $fatal(1);
  end

  function automatic int sz_bytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
    int lo;
    lo = int'(a % 4);
    if (sz_bytes(f3) == 1) return lo;
    if (sz_bytes(f3) == 2) return (lo / 2) * 2;
    return 0;
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int v;
    v = ((1 << sz_bytes(f3)) - 1) << lane_off(f3, a);
    return 4'(v);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (sz_bytes(f3) == 1) return (wd % 256) * 32'h0101_0101;
    if (sz_bytes(f3) == 2) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] word);
    logic [31:0] mask, v;
    int sz;
    sz = sz_bytes(f3);
    if (sz == 4) return word;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = (word >> (8 * lane_off(f3, a))) & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic bit ref_misalign(input logic [2:0] f3, input logic [31:0] a);
    if (sz_bytes(f3) == 2) return a[0];
    if (sz_bytes(f3) == 4) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  // Plays the controller and the memory for one access; observations only.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int g, input int r, input logic [31:0] word,
                            output obs_t o);
    int gc, rc;
    bit granted;
    o = '{default: 0};
    gc = 0; rc = 0; granted = 0;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Funct3 = f3; addr = a; wdata = wd;
    for (int i = 0; i < 40; i++) begin
      #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (done) begin
        o.done = 1; o.err = bus_err; o.rdata = rdata;
        break;
      end
      if (stall) o.stall_cyc++;
      if (mem_req) begin
        if (o.req_cyc == 0) begin
          o.maddr = mem_addr; o.be = mem_be; o.wd = mem_wdata; o.we = mem_we;
        end
        o.req_cyc++;
        if (gc == g) begin mem_gnt = 1'b1; granted = 1; end
        else gc++;
      end else if (granted && !wr) begin
        if (rc == r) begin mem_rvalid = 1'b1; mem_rdata = word; end
        else rc++;
      end
      @(negedge clk);
    end
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    o.spurious = done | stall | mem_req;
    @(negedge clk);
    #1;
    o.spurious = o.spurious | done | mem_req;
  endtask

  task automatic test_reset();
    reset = 1'b1; MemRead = 0; MemWrite = 0; Funct3 = 0; addr = 0; wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (bus_err !== 1'b0) begin errors++; $display("FAIL reset_bus_err got %b want 0", bus_err); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
    checks++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL reset_bus_fields got we=%b be=%b addr=%h wd=%h want all 0", mem_we, mem_be, mem_addr, mem_wdata); end
    mem_gnt = 1'b1; mem_rvalid = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    checks++; if ({done, mem_req, stall} !== 3'b000) begin errors++; $display("FAIL stray_idle got done/req/stall=%b want 000", {done, mem_req, stall}); end
    model_rdata = 32'h0;
  endtask

  task automatic test_store_word();
    obs_t o;
    run_access(1'b0, 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 2, 0, 32'h0, o);
    checks++; if (o.maddr !== 32'h100) begin errors++; $display("FAIL sw_addr got %h want 00000100", o.maddr); end
    checks++; if (o.be !== 4'b1111) begin errors++; $display("FAIL sw_be got %b want 1111", o.be); end
    checks++; if (o.wd !== 32'hDEADBEEF || o.we !== 1'b1) begin errors++; $display("FAIL sw_wdata got %h we=%b want deadbeef we=1", o.wd, o.we); end
    checks++; if (o.done !== 1'b1 || o.err !== 1'b0) begin errors++; $display("FAIL sw_done got done=%b err=%b want 1 0", o.done, o.err); end
    checks++; if (o.stall_cyc != 4 || o.req_cyc != 3) begin errors++; $display("FAIL sw_latency got stall=%0d req=%0d want 4 3", o.stall_cyc, o.req_cyc); end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80FF7F01, o);
    checks++; if (o.rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_rdata got %h want ffffff80", o.rdata); end
    checks++; if (o.stall_cyc != 4 || o.be !== 4'b1000) begin errors++; $display("FAIL lb_latency_be got stall=%0d be=%b want 4 1000", o.stall_cyc, o.be); end
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 1, 0, 32'h80FF7F01, o);
    checks++; if (o.rdata !== 32'h00000080 || o.err !== 1'b0) begin errors++; $display("FAIL lbu_rdata got %h err=%b want 00000080 0", o.rdata, o.err); end
    model_rdata = 32'h00000080;
  endtask

  task automatic test_load_half();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 0, 0, 32'h80FF7F01, o);
    checks++; if (o.rdata !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_rdata got %h want ffff80ff", o.rdata); end
    run_access(1'b0, 1'b1, 3'b001, 32'h102, 32'h00001234, 0, 0, 32'h0, o);
    checks++; if (o.be !== 4'b1100 || o.wd !== 32'h12341234) begin errors++; $display("FAIL sh_lanes got be=%b wd=%h want 1100 12341234", o.be, o.wd); end
    checks++; if (o.rdata !== 32'hFFFF80FF) begin errors++; $display("FAIL sh_rdata_hold got %h want ffff80ff", o.rdata); end
    model_rdata = 32'hFFFF80FF;
  endtask

  task automatic test_misalign();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 0, 32'hCAFEF00D, o);
    if (TRAP) begin
      checks++; if (o.req_cyc != 0 || o.stall_cyc != 1) begin errors++; $display("FAIL mis_trap_req got req=%0d stall=%0d want 0 1", o.req_cyc, o.stall_cyc); end
      checks++; if (o.done !== 1'b1 || o.err !== 1'b1 || o.rdata !== model_rdata) begin errors++; $display("FAIL mis_trap_done got done=%b err=%b rdata=%h want 1 1 %h", o.done, o.err, o.rdata, model_rdata); end
    end else begin
      checks++; if (o.maddr !== 32'h100 || o.be !== 4'b1111) begin errors++; $display("FAIL mis_pass_bus got addr=%h be=%b want 00000100 1111", o.maddr, o.be); end
      checks++; if (o.rdata !== 32'hCAFEF00D || o.err !== 1'b0) begin errors++; $display("FAIL mis_pass_rdata got %h err=%b want cafef00d 0", o.rdata, o.err); end
      model_rdata = 32'hCAFEF00D;
    end
  endtask

  task automatic test_random();
    obs_t o;
    bit rd, wr, mis, exp_err;
    logic [2:0] f3;
    logic [31:0] a, wd, word;
    int g, r, exp_req, exp_wait;
    for (int n = 0; n < 60; n++) begin
      case ($urandom % 3)
        0:       begin rd = 1; wr = 0; end
        1:       begin rd = 0; wr = 1; end
        default: begin rd = 1; wr = 1; end
      endcase
      f3 = 3'($urandom % 8);
      a = 32'h1000 + ($urandom % 64);
      wd = $urandom; word = $urandom;
      g = $urandom_range(0, 4);
      r = $urandom_range(0, 4);
      run_access(rd, wr, f3, a, wd, g, r, word, o);
      mis = TRAP && ref_misalign(f3, a);
      exp_req = 0; exp_wait = 0; exp_err = 0;
      if (mis) begin
        exp_err = 1;
      end else begin
        exp_req = (g >= TMO) ? TMO : g + 1;
        if (g >= TMO) begin
          exp_err = 1; model_rdata = 32'h0;
        end else if (!wr) begin
          exp_wait = (r >= TMO) ? TMO : r + 1;
          if (r >= TMO) begin exp_err = 1; model_rdata = 32'h0; end
          else model_rdata = ref_load(f3, a, word);
        end
      end
      checks++; if (o.done !== 1'b1 || o.err !== exp_err) begin errors++; $display("FAIL rnd%0d_done got done=%b err=%b want 1 %b", n, o.done, o.err, exp_err); end
      checks++; if (o.rdata !== model_rdata) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h (f3=%b a=%h w=%h)", n, o.rdata, model_rdata, f3, a, word); end
      checks++; if (o.req_cyc != exp_req || o.stall_cyc != 1 + exp_req + exp_wait) begin errors++; $display("FAIL rnd%0d_timing got req=%0d stall=%0d want %0d %0d", n, o.req_cyc, o.stall_cyc, exp_req, 1 + exp_req + exp_wait); end
      checks++; if (o.spurious !== 1'b0) begin errors++; $display("FAIL rnd%0d_after_done got spurious activity want none", n); end
      if (exp_req > 0) begin
        checks++; if (o.maddr !== (a & ~32'd3) || o.be !== ref_be(f3, a) || o.we !== wr) begin errors++; $display("FAIL rnd%0d_bus got addr=%h be=%b we=%b want %h %b %b", n, o.maddr, o.be, o.we, a & ~32'd3, ref_be(f3, a), wr); end
        if (wr) begin
          checks++; if (o.wd !== ref_wdata(f3, wd)) begin errors++; $display("FAIL rnd%0d_wdata got %h want %h", n, o.wd, ref_wdata(f3, wd)); end
        end
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b1, 1'b0, 3'b000, 32'h300, 32'h0, 99, 0, 32'h0, o);
    checks++; if (o.req_cyc != TMO) begin errors++; $display("FAIL tmo_req_cycles got %0d want %0d", o.req_cyc, TMO); end
    checks++; if (o.done !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin errors++; $display("FAIL tmo_result got done=%b err=%b rdata=%h want 1 1 0", o.done, o.err, o.rdata); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; addr = 32'h200;
    @(negedge clk);
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req got %b want 1", mem_req); end
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL rst_mid_wait got req=%b stall=%b want 0 1", mem_req, stall); end
    MemRead = 1'b0;
    reset = 1'b1;
    #1;
    checks++; if ({mem_req, stall, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_async got req/stall/done=%b want 000", {mem_req, stall, done}); end
    @(negedge clk);
    reset = 1'b0; mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    #1;
    checks++; if (done !== 1'b0 || rdata !== 32'h0 || mem_req !== 1'b0) begin errors++; $display("FAIL rst_mid_late got done=%b rdata=%h req=%b want 0 0 0", done, rdata, mem_req); end
    @(negedge clk);
    #1;
    checks++; if (done !== 1'b0 || bus_err !== 1'b0) begin errors++; $display("FAIL rst_mid_quiet got done=%b err=%b want 0 0", done, bus_err); end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half();
    test_misalign();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
